ps2_scancode_sequencer: RTL and testbench
=========================================

Name: ps2_scancode_sequencer

Overview:
- Sequences the raw byte stream from the PS/2 receiver into complete key events: make, break, extended make and extended break.
- Drives the 32-bit keyCode bus consumed by the keyboard decoder: upper half holds the prefix, lower half holds the scancode.
- Tracks held state of game keys A, D and SPACE, so releasing one key while another is held never drops the held one.
- Watchdog discards orphan prefixes.

Parameters:
- TIMEOUT_CYCLES, 2_000_000, clock cycles allowed between a prefix byte and its following byte before the FSM aborts (20 ms at 100 MHz).
- CNT_W, 21, width of the watchdog counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received scancode byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- keyCode  output  32  {prefix[15:0], code[15:0]}, registered, held until the next event
- key_valid  output  1  one-cycle pulse, coincident with keyCode update
- held_keys  output  3  bit0 = A, bit1 = D, bit2 = SPACE; 1 = currently held
- seq_error  output  1  one-cycle pulse on timeout or illegal byte order

Behaviour:
- One clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: keyCode = 0, key_valid = 0, held_keys = 0, seq_error = 0, FSM = IDLE, watchdog = 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- Transitions on rx_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte xx -> emit make, keyCode = 32'h0000_00xx, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> seq_error, stay EXT; xx -> emit 32'hE000_00xx, -> IDLE.
  - BRK: xx (not E0/F0) -> emit 32'h00F0_00xx, -> IDLE; E0 or F0 -> seq_error, -> IDLE, no emit.
  - EXT_BRK: xx -> emit 32'hE0F0_00xx, -> IDLE; E0 or F0 -> seq_error, -> IDLE.
- Latency: keyCode and key_valid update on the clock edge after the final byte's rx_valid (1 cycle).
- Byte AA (BAT OK) in IDLE: ignored, no emit.
- held_keys:
  - Non-extended make of A/D/SPACE sets the matching bit.
  - Non-extended break of the same key clears it.
  - Extended codes never touch held_keys.
- Watchdog:
  - Counts while the FSM is in EXT, BRK or EXT_BRK; cleared on any rx_valid or on return to IDLE.
  - Reaching TIMEOUT_CYCLES-1: FSM -> IDLE, seq_error pulse, no emit.
- Simultaneous timeout and rx_valid: rx_valid wins; byte processed normally, no error.
- rx_valid held high on consecutive cycles: each cycle is a separate byte.
- Reset mid-sequence: partial prefix discarded, held_keys cleared.
- keyCode holds its last value between events; key_valid is the only event marker.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined: a non-extended make for a key whose held_keys bit is already 1 (autorepeat) updates nothing and produces no key_valid.
- Undefined: every make code emits, including autorepeat.

Decomposition:
- keyboard_pkg holds:
  - 16-bit constants A = 16'h001C, D = 16'h0023, SPACE = 16'h0029, RELEASED = 16'h00F0.
  - 8-bit constants EXTENDED = 8'hE0, BREAK = 8'hF0, BAT_OK = 8'hAA.
  - FSM enum seq_state_t.
  - Held-key index constants.
- One natural sub-module: ps2_seq_watchdog (counter, clear, enable, timeout pulse).

Test Plan:
- Bytes 1C, then F0 1C -> key_valid with keyCode 32'h0000_001C, held_keys = 3'b001; then 32'h00F0_001C, held_keys = 3'b000.
- 1C, 23, F0 1C -> held_keys 001 -> 011 -> 010; D remains held after A released.
- E0 F0 74 -> single key_valid, keyCode = 32'hE0F0_0074, held_keys unchanged; no pulse on the prefix bytes.
- F0, then no byte for TIMEOUT_CYCLES (override to 16) -> seq_error pulse at cycle 16, FSM IDLE; next byte 29 -> keyCode 32'h0000_0029, held_keys = 3'b100.
- 29 repeated 3× -> three key_valid without TYPEMATIC_FILTER_EN, one with it.
- E0 sent, rst asserted next cycle, then 1C -> keyCode = 32'h0000_001C (prefix discarded), held_keys = 3'b001.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared constants, FSM state type and held-key helper for the PS/2
// scancode sequencer. Used by ps2_scancode_sequencer and its bench.
// The TYPEMATIC_FILTER_EN option does not change anything in this package.
package keyboard_pkg;

    // 16-bit scancode views of the tracked game keys and of the break prefix
    localparam logic [15:0] A        = 16'h001C;
    localparam logic [15:0] D        = 16'h0023;
    localparam logic [15:0] SPACE    = 16'h0029;
    localparam logic [15:0] RELEASED = 16'h00F0;

    // Raw prefix / status bytes as they arrive from the receiver
    localparam logic [7:0] EXTENDED = 8'hE0;
    localparam logic [7:0] BREAK    = 8'hF0;
    localparam logic [7:0] BAT_OK   = 8'hAA;

    // Bit positions inside held_keys
    localparam int HELD_A     = 0;
    localparam int HELD_D     = 1;
    localparam int HELD_SPACE = 2;
    localparam int HELD_W     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } seq_state_t;

    // One-hot held_keys mask for a scancode byte; zero for untracked keys
    function automatic logic [HELD_W-1:0] held_mask(input logic [7:0] code);
        logic [HELD_W-1:0] m;
        m = '0;
        if ({8'h00, code} == A)     m[HELD_A]     = 1'b1;
        if ({8'h00, code} == D)     m[HELD_D]     = 1'b1;
        if ({8'h00, code} == SPACE) m[HELD_SPACE] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ps2_scancode_sequencer_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver side and the
// keyboard decoder side. The sequencer is the slave: it takes bytes in and
// drives key events out. The master modport is the producer/consumer side.
interface ps2_scancode_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] keyCode;
    logic        key_valid;
    logic [2:0]  held_keys;
    logic        seq_error;

    modport master (
        output rx_data, rx_valid,
        input  keyCode, key_valid, held_keys, seq_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output keyCode, key_valid, held_keys, seq_error
    );
endinterface

// File: rtl/ps2_seq_watchdog.sv
// Prefix watchdog: counts cycles while a multi-byte sequence is open and
// fires a one-cycle timeout when the count reaches TIMEOUT_CYCLES-1.
// A clear in the same cycle suppresses the timeout, so a byte arriving on
// the expiry cycle is processed normally.
module ps2_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_timeout = i_en && !i_clr && (r_count == LAST);

    // Counter: restart on clear or expiry, otherwise advance while enabled
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst || i_clr || o_timeout) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// PS/2 scancode sequencer: folds E0/F0 prefixes and the following byte into
// one key event on a 32-bit {prefix, code} bus, tracks held A/D/SPACE, and
// drops orphan prefixes via a watchdog.
// Optional macro TYPEMATIC_FILTER_EN: when defined, a non-extended make of a
// key that is already held (autorepeat) is swallowed with no event.
module ps2_scancode_sequencer
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    ps2_scancode_sequencer_if.slave  bus
);

    seq_state_t          r_state;
    seq_state_t          w_next_state;

    logic                w_emit;
    logic                w_err;
    logic [15:0]         w_prefix;
    logic [HELD_W-1:0]   w_mask;
    logic [HELD_W-1:0]   w_held_next;

    logic [31:0]         r_key_code;
    logic                r_key_valid;
    logic [HELD_W-1:0]   r_held;
    logic                r_seq_error;

    logic                w_wd_en;
    logic                w_wd_clr;
    logic                w_timeout;

    // Watchdog runs only while a prefix is outstanding; any byte restarts it
    assign w_wd_en  = (r_state != IDLE);
    assign w_wd_clr = bus.rx_valid || (r_state == IDLE);

    ps2_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_wd_en),
        .i_clr     (w_wd_clr),
        .o_timeout (w_timeout)
    );

    assign w_mask = held_mask(bus.rx_data);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, event decode and held-key update
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        w_prefix     = 16'h0000;
        w_held_next  = r_held;

        if (bus.rx_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.rx_data == EXTENDED) begin
                        w_next_state = EXT;
                    end else if (bus.rx_data == BREAK) begin
                        w_next_state = BRK;
                    end else if (bus.rx_data != BAT_OK) begin
`ifdef TYPEMATIC_FILTER_EN
                        if ((w_mask & r_held) == '0) begin
                            w_emit      = 1'b1;
                            w_held_next = r_held | w_mask;
                        end
`else
                        w_emit      = 1'b1;
                        w_held_next = r_held | w_mask;
`endif
                    end
                end

                EXT: begin
                    if (bus.rx_data == BREAK) begin
                        w_next_state = EXT_BRK;
                    end else if (bus.rx_data == EXTENDED) begin
                        w_err = 1'b1;
                    end else begin
                        w_emit       = 1'b1;
                        w_prefix     = {EXTENDED, 8'h00};
                        w_next_state = IDLE;
                    end
                end

                BRK: begin
                    w_next_state = IDLE;
                    if (bus.rx_data == EXTENDED || bus.rx_data == BREAK) begin
                        w_err = 1'b1;
                    end else begin
                        w_emit      = 1'b1;
                        w_prefix    = RELEASED;
                        w_held_next = r_held & ~w_mask;
                    end
                end

                EXT_BRK: begin
                    w_next_state = IDLE;
                    if (bus.rx_data == EXTENDED || bus.rx_data == BREAK) begin
                        w_err = 1'b1;
                    end else begin
                        w_emit   = 1'b1;
                        w_prefix = {EXTENDED, BREAK};
                    end
                end

                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_next_state = IDLE;
            w_err        = 1'b1;
        end
    end

    // Registered event outputs; keyCode holds between events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 32'h0;
            r_key_valid <= 1'b0;
            r_held      <= '0;
            r_seq_error <= 1'b0;
        end else begin
            r_key_valid <= w_emit;
            r_seq_error <= w_err;
            r_held      <= w_held_next;
            if (w_emit) begin
                r_key_code <= {w_prefix, 8'h00, bus.rx_data};
            end
        end
    end

    assign bus.keyCode   = r_key_code;
    assign bus.key_valid = r_key_valid;
    assign bus.held_keys = r_held;
    assign bus.seq_error = r_seq_error;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Bench for ps2_scancode_sequencer: directed byte sequences, a sequence-level
// model compared on every cycle, and literal expectations at key points.
// Works with or without TYPEMATIC_FILTER_EN defined.
module tb_ps2_scancode_sequencer;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;

    ps2_scancode_sequencer_if bus ();

    ps2_scancode_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- sequence-level model ----------------
    logic [7:0]  m_pend[$];
    logic [31:0] m_code;
    logic        m_valid;
    logic [2:0]  m_held;
    logic        m_err;
    logic        m_live = 1'b0;
    int          m_cyc  = 0;
    int          m_last = 0;
    logic [7:0]  m_b;
    logic [15:0] m_pfx;

    function automatic logic [2:0] key_bits(input logic [7:0] b);
        case (b)
            8'h1C:   return 3'b001;
            8'h23:   return 3'b010;
            8'h29:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task model_emit(input logic [15:0] pfx, input logic [7:0] b);
        if (pfx == 16'h0000) begin
`ifdef TYPEMATIC_FILTER_EN
            if ((key_bits(b) & m_held) != 3'b000) return;
`endif
            m_held = m_held | key_bits(b);
        end else if (pfx == 16'h00F0) begin
            m_held = m_held & ~key_bits(b);
        end
        m_valid = 1'b1;
        m_code  = {pfx, 8'h00, b};
    endtask

    always @(posedge clk) begin
        m_cyc++;
        if (rst) begin
            m_live = 1'b1;
            m_pend.delete();
            m_code  = 32'h0;
            m_valid = 1'b0;
            m_held  = 3'b000;
            m_err   = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (bus.rx_valid) begin
                m_b    = bus.rx_data;
                m_last = m_cyc;
                if (m_pend.size() == 0) begin
                    if (m_b == 8'hE0 || m_b == 8'hF0) m_pend.push_back(m_b);
                    else if (m_b != 8'hAA) model_emit(16'h0000, m_b);
                end else if (m_pend.size() == 1 && m_pend[0] == 8'hE0 && m_b == 8'hF0) begin
                    m_pend.push_back(m_b);
                end else if (m_pend.size() == 1 && m_pend[0] == 8'hE0 && m_b == 8'hE0) begin
                    m_err = 1'b1;
                end else if (m_b == 8'hE0 || m_b == 8'hF0) begin
                    m_err = 1'b1;
                    m_pend.delete();
                end else begin
                    if (m_pend.size() == 2)      m_pfx = 16'hE0F0;
                    else if (m_pend[0] == 8'hE0) m_pfx = 16'hE000;
                    else                         m_pfx = 16'h00F0;
                    model_emit(m_pfx, m_b);
                    m_pend.delete();
                end
            end else if (m_pend.size() != 0 && (m_cyc - m_last) == TIMEOUT) begin
                m_err = 1'b1;
                m_pend.delete();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            check("model keyCode",   bus.keyCode,          m_code);
            check("model key_valid", {31'h0, bus.key_valid}, {31'h0, m_valid});
            check("model held_keys", {29'h0, bus.held_keys}, {29'h0, m_held});
            check("model seq_error", {31'h0, bus.seq_error}, {31'h0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_event(input string name, input logic [31:0] code, input logic [2:0] held);
        check({name, " code"},  bus.keyCode, code);
        check({name, " valid"}, {31'h0, bus.key_valid}, 32'd1);
        check({name, " held"},  {29'h0, bus.held_keys}, {29'h0, held});
    endtask

    int n_pulses;

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset keyCode",   bus.keyCode, 32'h0);
        check("reset key_valid", {31'h0, bus.key_valid}, 32'd0);
        check("reset held",      {29'h0, bus.held_keys}, 32'd0);
        check("reset seq_error", {31'h0, bus.seq_error}, 32'd0);
        rst = 1'b0;

        // A make then break
        send_byte(8'h1C); expect_event("A make", 32'h0000_001C, 3'b001);
        send_byte(8'hF0);
        check("F0 no pulse", {31'h0, bus.key_valid}, 32'd0);
        send_byte(8'h1C); expect_event("A break", 32'h00F0_001C, 3'b000);

        // Overlapping A and D; D survives A release
        send_byte(8'h1C); expect_event("A make2", 32'h0000_001C, 3'b001);
        send_byte(8'h23); expect_event("D make",  32'h0000_0023, 3'b011);
        send_byte(8'hF0);
        send_byte(8'h1C); expect_event("A rel D held", 32'h00F0_001C, 3'b010);
        send_byte(8'hF0);
        send_byte(8'h23); expect_event("D break", 32'h00F0_0023, 3'b000);

        // Extended break: one event, held untouched
        send_byte(8'hE0);
        check("E0 no pulse", {31'h0, bus.key_valid}, 32'd0);
        send_byte(8'hF0);
        check("E0F0 no pulse", {31'h0, bus.key_valid}, 32'd0);
        send_byte(8'h74); expect_event("ext break", 32'hE0F0_0074, 3'b000);

        // Orphan F0 times out on the 16th cycle after it
        send_byte(8'hF0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("timeout early", {31'h0, bus.seq_error}, 32'd0);
        @(negedge clk);
        check("timeout pulse", {31'h0, bus.seq_error}, 32'd1);
        check("timeout no emit", {31'h0, bus.key_valid}, 32'd0);
        send_byte(8'h29); expect_event("SPACE after timeout", 32'h0000_0029, 3'b100);
        send_byte(8'hF0);
        send_byte(8'h29); expect_event("SPACE break", 32'h00F0_0029, 3'b000);

        // Back-to-back autorepeat of SPACE
        n_pulses = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h29;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_pulses += int'(bus.key_valid);
            if (i == 2) bus.rx_valid = 1'b0;
        end
`ifdef TYPEMATIC_FILTER_EN
        check("autorepeat pulses", n_pulses, 32'd1);
`else
        check("autorepeat pulses", n_pulses, 32'd3);
`endif

        // Reset mid-sequence discards the prefix and held state
        send_byte(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h1C); expect_event("after reset", 32'h0000_001C, 3'b001);

        // Illegal orders
        send_byte(8'hE0);
        send_byte(8'hE0);
        check("E0E0 error", {31'h0, bus.seq_error}, 32'd1);
        send_byte(8'h12); expect_event("ext make", 32'hE000_0012, 3'b001);
        send_byte(8'hF0);
        send_byte(8'hE0);
        check("F0E0 error", {31'h0, bus.seq_error}, 32'd1);
        check("F0E0 no emit", {31'h0, bus.key_valid}, 32'd0);
        send_byte(8'hAA);
        check("BAT ignored", {31'h0, bus.key_valid}, 32'd0);
        check("BAT holds code", bus.keyCode, 32'hE000_0012);

        // Byte lands on the expiry cycle: it wins, no error
        send_byte(8'hF0);
        repeat (TIMEOUT - 2) @(negedge clk);
        send_byte(8'h1C); expect_event("byte beats timeout", 32'h00F0_001C, 3'b000);
        check("no timeout error", {31'h0, bus.seq_error}, 32'd0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
